// File: rtl/dram_resp.sv
// rtl/dram_resp.sv - DRAM responder: fixed-latency accelerator read/write port plus arbitrated host port
// Accelerator traffic always wins over the host; memory contents survive reset.
module dram_resp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int MEM_AW     = 18,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  dram_en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  dram_valid,
  input  logic                  dram_en_wr,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
);
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic {IDLE, GRANT} host_state_t;
  host_state_t state, state_nxt;
  logic        host_accept;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [MEM_AW-1:0]     rd_idx, wr_idx, host_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  pipe_v [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_d [RD_LATENCY];

  // Upper address bits are dropped, so every port aliases modulo DEPTH.
  assign rd_idx   = addr_in[MEM_AW-1:0];
  assign wr_idx   = addr_out[MEM_AW-1:0];
  assign host_idx = host_addr[MEM_AW-1:0];

  // Write-first: a same-cycle accelerator write to the read location is forwarded.
  assign rd_word = (dram_en_wr && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (srstn) begin
      if (dram_en_wr) begin
        mem[wr_idx] <= wr_data;
      end else if (host_accept && host_we) begin
        mem[host_idx] <= host_wdata;
      end
    end
  end

  // Each data stage loads only behind a valid, so the last stage holds the last returned word.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= dram_en_rd;
      if (dram_en_rd) begin
        pipe_d[0] <= rd_word;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
        end
      end
    end
  end

  assign dram_valid = pipe_v[RD_LATENCY-1];
  assign rd_data    = pipe_d[RD_LATENCY-1];

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    host_accept = 1'b0;
    case (state)
      IDLE: begin
        if (host_req && !dram_en_rd && !dram_en_wr) begin
          host_accept = 1'b1;
          state_nxt   = GRANT;
        end
      end
      GRANT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign host_ack = (state == GRANT);

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      host_rdata <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
    end else begin
      if (host_accept && !host_we) begin
        host_rdata <= mem[host_idx];
      end
      if (dram_en_rd && (rd_cnt != '1)) begin
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (dram_en_wr && (wr_cnt != '1)) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_dram_resp.sv
// tb/tb_dram_resp.sv - table-driven and randomized check of dram_resp at read latencies 1 and 3
// Both instances share stimulus; a queue-based model predicts every output each cycle.
module tb_dram_resp;
  localparam int DW  = 32;
  localparam int AW  = 18;
  localparam int MAW = 4;
  localparam logic [31:0] P = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic srstn = 1'b0;
  logic rd = 1'b0, wr = 1'b0, hreq = 1'b0, hwe = 1'b0;
  logic [AW-1:0] ra = '0, wa = '0, ha = '0;
  logic [DW-1:0] wd = '0, hwd = '0;
  logic [DW-1:0] rdd1, rdd3, hrd1, hrd3;
  logic v1, v3, ack1, ack3;
  logic [31:0] rc1, rc3, wc1, wc3;

  always #5 clk = ~clk;

  dram_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(MAW), .RD_LATENCY(1)) u1 (
    .clk(clk), .srstn(srstn), .dram_en_rd(rd), .addr_in(ra), .rd_data(rdd1), .dram_valid(v1),
    .dram_en_wr(wr), .addr_out(wa), .wr_data(wd), .host_req(hreq), .host_we(hwe),
    .host_addr(ha), .host_wdata(hwd), .host_ack(ack1), .host_rdata(hrd1), .rd_cnt(rc1), .wr_cnt(wc1));

  dram_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(MAW), .RD_LATENCY(3)) u3 (
    .clk(clk), .srstn(srstn), .dram_en_rd(rd), .addr_in(ra), .rd_data(rdd3), .dram_valid(v3),
    .dram_en_wr(wr), .addr_out(wa), .wr_data(wd), .host_req(hreq), .host_we(hwe),
    .host_addr(ha), .host_wdata(hwd), .host_ack(ack3), .host_rdata(hrd3), .rd_cnt(rc3), .wr_cnt(wc3));

  typedef struct { int due; logic [31:0] d; } resp_t;
  resp_t q1[$], q3[$];
  logic [31:0] m [16];
  logic [31:0] last1, last3, m_hr, m_rc, m_wc;
  int last_acc, step, nvec, nbad;

  typedef struct {
    logic rd; logic [AW-1:0] ra; logic wr; logic [AW-1:0] wa; logic [31:0] wd;
    logic hq; logic hw; logic [AW-1:0] ha; logic [31:0] hd;
    logic v1; logic [31:0] d1; logic v3; logic [31:0] d3;
    logic ack; logic [31:0] hr; logic [31:0] rc; logic [31:0] wc;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s at step %0d: got %h, expected %h", name, step, act, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q3.delete();
    last1 = '0; last3 = '0; m_hr = '0; m_rc = '0; m_wc = '0;
    last_acc = -10;
  endtask

  // Predicts the effect of the inputs now on the bus at the coming clock edge.
  task automatic model_apply();
    resp_t r;
    int ri, wi, hi;
    if (!srstn) return;
    ri = int'(ra % 16); wi = int'(wa % 16); hi = int'(ha % 16);
    if (rd) begin
      r.d = (wr && ri == wi) ? wd : m[ri];
      r.due = step + 1; q1.push_back(r);
      r.due = step + 3; q3.push_back(r);
      if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
    end
    if (wr) begin
      m[wi] = wd;
      if (m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 1;
    end
    if (hreq && !rd && !wr && last_acc != step - 1) begin
      last_acc = step;
      if (hwe) m[hi] = hwd;
      else     m_hr = m[hi];
    end
  endtask

  task automatic model_check();
    resp_t r;
    logic e1, e3, ea;
    e1 = 1'b0; e3 = 1'b0;
    if (q1.size() > 0 && q1[0].due == step) begin e1 = 1'b1; r = q1.pop_front(); last1 = r.d; end
    if (q3.size() > 0 && q3[0].due == step) begin e3 = 1'b1; r = q3.pop_front(); last3 = r.d; end
    ea = (last_acc == step - 1);
    chk("m_valid1", v1, e1);     chk("m_rdata1", rdd1, last1);
    chk("m_valid3", v3, e3);     chk("m_rdata3", rdd3, last3);
    chk("m_ack1", ack1, ea);     chk("m_ack3", ack3, ea);
    chk("m_hrdata1", hrd1, m_hr); chk("m_hrdata3", hrd3, m_hr);
    chk("m_rdcnt1", rc1, m_rc);  chk("m_rdcnt3", rc3, m_rc);
    chk("m_wrcnt1", wc1, m_wc);  chk("m_wrcnt3", wc3, m_wc);
  endtask

  task automatic tick(input logic i_rd, input logic [AW-1:0] i_ra, input logic i_wr,
                      input logic [AW-1:0] i_wa, input logic [31:0] i_wd, input logic i_hq,
                      input logic i_hw, input logic [AW-1:0] i_ha, input logic [31:0] i_hd);
    rd = i_rd; ra = i_ra; wr = i_wr; wa = i_wa; wd = i_wd;
    hreq = i_hq; hwe = i_hw; ha = i_ha; hwd = i_hd;
    model_apply();
    @(negedge clk);
    step++;
    model_check();
  endtask

  task automatic idle();
    tick(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic add(input logic i_rd, input logic [AW-1:0] i_ra, input logic i_wr,
                     input logic [AW-1:0] i_wa, input logic [31:0] i_wd, input logic i_hq,
                     input logic i_hw, input logic [AW-1:0] i_ha, input logic [31:0] i_hd,
                     input logic e_v1, input logic [31:0] e_d1, input logic e_v3, input logic [31:0] e_d3,
                     input logic e_ack, input logic [31:0] e_hr, input logic [31:0] e_rc, input logic [31:0] e_wc);
    vec_t v;
    v.rd = i_rd; v.ra = i_ra; v.wr = i_wr; v.wa = i_wa; v.wd = i_wd;
    v.hq = i_hq; v.hw = i_hw; v.ha = i_ha; v.hd = i_hd;
    v.v1 = e_v1; v.d1 = e_d1; v.v3 = e_v3; v.d3 = e_d3;
    v.ack = e_ack; v.hr = e_hr; v.rc = e_rc; v.wc = e_wc;
    tbl.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic hp, hpw;
    logic [AW-1:0] hpa;
    logic [31:0] hpd;
    nvec = 0; nbad = 0; step = 0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_valid1", v1, 1'b0);  chk("rst_rdata1", rdd1, 32'h0);
    chk("rst_valid3", v3, 1'b0);  chk("rst_ack", ack1, 1'b0);
    chk("rst_hrdata", hrd1, 32'h0); chk("rst_rdcnt", rc1, 32'h0); chk("rst_wrcnt", wc1, 32'h0);
    srstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      tick(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(i), P | 32'(i));
      idle();
    end

    //   rd ra      wr wa       wd            hq hw ha       hd            | v1 d1            v3 d3            ack hr            rc  wc
    add(0, 0,      0, 0,       0,            1, 1, 5,       32'h00010000, 0, 0,            0, 0,            1, 0,            0,  0);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 0,            0, 0,            0, 0,            0,  0);
    add(0, 0,      0, 0,       0,            1, 1, 6,       32'hFFFF8000, 0, 0,            0, 0,            1, 0,            0,  0);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 0,            0, 0,            0, 0,            0,  0);
    add(0, 0,      0, 0,       0,            1, 0, 6,       0,            0, 0,            0, 0,            1, 32'hFFFF8000, 0,  0);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 0,            0, 0,            0, 32'hFFFF8000, 0,  0);
    add(1, 5,      0, 0,       0,            0, 0, 0,       0,            1, 32'h00010000, 0, 0,            0, 32'hFFFF8000, 1,  0);
    add(1, 6,      0, 0,       0,            0, 0, 0,       0,            1, 32'hFFFF8000, 0, 0,            0, 32'hFFFF8000, 2,  0);
    add(1, 7,      0, 0,       0,            0, 0, 0,       0,            1, 32'hA5A50007, 1, 32'h00010000, 0, 32'hFFFF8000, 3,  0);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 32'hA5A50007, 1, 32'hFFFF8000, 0, 32'hFFFF8000, 3,  0);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 32'hA5A50007, 1, 32'hA5A50007, 0, 32'hFFFF8000, 3,  0);
    add(1, 9,      1, 9,       32'h1234,     0, 0, 0,       0,            1, 32'h1234,     0, 32'hA5A50007, 0, 32'hFFFF8000, 4,  1);
    add(1, 9,      0, 0,       0,            0, 0, 0,       0,            1, 32'h1234,     0, 32'hA5A50007, 0, 32'hFFFF8000, 5,  1);
    add(0, 0,      1, 9,       32'h5678,     0, 0, 0,       0,            0, 32'h1234,     1, 32'h1234,     0, 32'hFFFF8000, 5,  2);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 32'h1234,     1, 32'h1234,     0, 32'hFFFF8000, 5,  2);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 32'h1234,     0, 32'h1234,     0, 32'hFFFF8000, 5,  2);
    add(1, 0,      0, 0,       0,            1, 0, 5,       0,            1, 32'hA5A50000, 0, 32'h1234,     0, 32'hFFFF8000, 6,  2);
    add(1, 1,      0, 0,       0,            1, 0, 5,       0,            1, 32'hA5A50001, 0, 32'h1234,     0, 32'hFFFF8000, 7,  2);
    add(1, 2,      0, 0,       0,            1, 0, 5,       0,            1, 32'hA5A50002, 1, 32'hA5A50000, 0, 32'hFFFF8000, 8,  2);
    add(1, 3,      0, 0,       0,            1, 0, 5,       0,            1, 32'hA5A50003, 1, 32'hA5A50001, 0, 32'hFFFF8000, 9,  2);
    add(0, 0,      0, 0,       0,            1, 0, 5,       0,            0, 32'hA5A50003, 1, 32'hA5A50002, 1, 32'h00010000, 9,  2);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 32'hA5A50003, 1, 32'hA5A50003, 0, 32'h00010000, 9,  2);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 32'hA5A50003, 0, 32'hA5A50003, 0, 32'h00010000, 9,  2);
    add(0, 0,      1, 'h13,    32'hCAFEF00D, 0, 0, 0,       0,            0, 32'hA5A50003, 0, 32'hA5A50003, 0, 32'h00010000, 9,  3);
    add(1, 3,      0, 0,       0,            0, 0, 0,       0,            1, 32'hCAFEF00D, 0, 32'hA5A50003, 0, 32'h00010000, 10, 3);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 32'hCAFEF00D, 0, 32'hA5A50003, 0, 32'h00010000, 10, 3);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0, 32'h00010000, 10, 3);
    add(0, 0,      0, 0,       0,            1, 0, 'h20013, 0,            0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 10, 3);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 10, 3);
    add(0, 0,      0, 0,       0,            1, 0, 5,       0,            0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1, 32'h00010000, 10, 3);
    add(0, 0,      0, 0,       0,            1, 0, 5,       0,            0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 32'h00010000, 10, 3);
    add(0, 0,      0, 0,       0,            1, 0, 5,       0,            0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1, 32'h00010000, 10, 3);
    add(0, 0,      0, 0,       0,            0, 0, 0,       0,            0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 32'h00010000, 10, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rd, tbl[i].ra, tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].hq, tbl[i].hw, tbl[i].ha, tbl[i].hd);
      chk("tbl_valid1", v1, tbl[i].v1);  chk("tbl_rdata1", rdd1, tbl[i].d1);
      chk("tbl_valid3", v3, tbl[i].v3);  chk("tbl_rdata3", rdd3, tbl[i].d3);
      chk("tbl_ack", ack1, tbl[i].ack);  chk("tbl_hrdata", hrd1, tbl[i].hr);
      chk("tbl_rdcnt", rc1, tbl[i].rc);  chk("tbl_wrcnt", wc1, tbl[i].wc);
    end

    // Reads in flight when reset asserts must never surface.
    tick(1'b1, 5, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    tick(1'b1, 6, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    idle();
    srstn = 1'b0;
    model_reset();
    #1;
    chk("midrst_valid3", v3, 1'b0);
    chk("midrst_rdata3", rdd3, 32'h0);
    chk("midrst_rdcnt", rc3, 32'h0);
    idle();
    idle();
    srstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("postrst_valid3", v3, 1'b0);
    end
    tick(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 5, '0);
    chk("postrst_ack", ack1, 1'b1);
    chk("postrst_hrdata", hrd1, 32'h00010000);
    chk("postrst_rdcnt", rc1, 32'h0);
    chk("postrst_wrcnt", wc1, 32'h0);
    idle();

    hp = 1'b0; hpw = 1'b0; hpa = '0; hpd = '0;
    for (int n = 0; n < 3000; n++) begin
      logic r, w;
      if (!hp && $urandom_range(0, 99) < 35) begin
        hp = 1'b1; hpw = 1'($urandom); hpa = AW'($urandom); hpd = $urandom;
      end
      r = ($urandom_range(0, 99) < 40);
      w = ($urandom_range(0, 99) < 30);
      tick(r, AW'($urandom), w, AW'($urandom), $urandom, hp, hpw, hpa, hpd);
      if (last_acc == step - 1) hp = 1'b0;
    end
    repeat (4) idle();

    // A full 2**32 burst is out of reach, so the write counter is preset just below the ceiling.
    force u1.wr_cnt = 32'hFFFF_FFF0;
    force u3.wr_cnt = 32'hFFFF_FFF0;
    #1;
    release u1.wr_cnt;
    release u3.wr_cnt;
    m_wc = 32'hFFFF_FFF0;
    chk("preset_wrcnt", wc1, 32'hFFFF_FFF0);
    for (int i = 0; i < 20; i++) begin
      tick(1'($urandom), AW'($urandom), 1'b1, AW'($urandom), $urandom, 1'b0, 1'b0, '0, '0);
    end
    chk("sat_wrcnt1", wc1, 32'hFFFF_FFFF);
    chk("sat_wrcnt3", wc3, 32'hFFFF_FFFF);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
